// File: rtl/toy_bus_arb_node_arb_dmem_ack.sv
`default_nettype none
// ============================================================================
// Module      : toy_bus_arb_node_arb_dmem_ack
// Description : Four-to-one round-robin merge of dmem response beats into a
//               single-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
module toy_bus_arb_node_arb_dmem_ack #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,
    input  logic              in1_vld,
    output logic              in1_rdy,
    input  logic [DATA_W-1:0] in1_data,
    input  logic [ID_W-1:0]   in1_src_id,
    input  logic [ID_W-1:0]   in1_tgt_id,
    input  logic              in2_vld,
    output logic              in2_rdy,
    input  logic [DATA_W-1:0] in2_data,
    input  logic [ID_W-1:0]   in2_src_id,
    input  logic [ID_W-1:0]   in2_tgt_id,
    input  logic              in3_vld,
    output logic              in3_rdy,
    input  logic [DATA_W-1:0] in3_data,
    input  logic [ID_W-1:0]   in3_src_id,
    input  logic [ID_W-1:0]   in3_tgt_id,
    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic [DATA_W-1:0] out0_data,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id
);

    logic [3:0]        w_vld;
    logic [DATA_W-1:0] w_data   [4];
    logic [ID_W-1:0]   w_src_id [4];
    logic [ID_W-1:0]   w_tgt_id [4];

    logic [3:0]        w_grant;
    logic [1:0]        w_sel;
    logic [1:0]        w_idx;
    logic              w_any;
    logic              w_can_load;
    logic              w_accept;

    logic [1:0]        r_ptr;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_data;
    logic [ID_W-1:0]   r_out_src_id;
    logic [ID_W-1:0]   r_out_tgt_id;

    assign w_vld       = {in3_vld, in2_vld, in1_vld, in0_vld};
    assign w_data[0]   = in0_data;
    assign w_data[1]   = in1_data;
    assign w_data[2]   = in2_data;
    assign w_data[3]   = in3_data;
    assign w_src_id[0] = in0_src_id;
    assign w_src_id[1] = in1_src_id;
    assign w_src_id[2] = in2_src_id;
    assign w_src_id[3] = in3_src_id;
    assign w_tgt_id[0] = in0_tgt_id;
    assign w_tgt_id[1] = in1_tgt_id;
    assign w_tgt_id[2] = in2_tgt_id;
    assign w_tgt_id[3] = in3_tgt_id;

    // First valid channel scanning upward from ptr, wrapping modulo 4.
    always_comb begin
        w_grant = 4'b0000;
        w_sel   = r_ptr;
        w_idx   = r_ptr;
        w_any   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_any && w_vld[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_sel          = w_idx;
                w_any          = 1'b1;
            end
        end
    end

    // Reset gates the handshake so no beat is consumed while rst is high.
    assign w_can_load = (!r_out_vld || out0_rdy) && !rst;
    assign w_accept   = w_any && w_can_load;

    assign in0_rdy = w_grant[0] && w_can_load;
    assign in1_rdy = w_grant[1] && w_can_load;
    assign in2_rdy = w_grant[2] && w_can_load;
    assign in3_rdy = w_grant[3] && w_can_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= 2'd0;
            r_out_vld    <= 1'b0;
            r_out_data   <= '0;
            r_out_src_id <= '0;
            r_out_tgt_id <= '0;
        end else if (w_accept) begin
            r_ptr        <= w_sel + 2'd1;
            r_out_vld    <= 1'b1;
            r_out_data   <= w_data[w_sel];
            r_out_src_id <= w_src_id[w_sel];
            r_out_tgt_id <= w_tgt_id[w_sel];
        end else if (r_out_vld && out0_rdy) begin
            r_out_vld    <= 1'b0;
        end
    end

    assign out0_vld    = r_out_vld;
    assign out0_data   = r_out_data;
    assign out0_src_id = r_out_src_id;
    assign out0_tgt_id = r_out_tgt_id;

endmodule
`default_nettype wire

// File: tb/tb_toy_bus_arb_node_arb_dmem_ack.sv
`default_nettype none
// ============================================================================
// Module      : tb_toy_bus_arb_node_arb_dmem_ack
// Description : Self-checking bench for the dmem response merge node.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toy_bus_arb_node_arb_dmem_ack;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        vld = 4'b0000;
    logic [3:0]        rdy;
    logic [DATA_W-1:0] din [4];
    logic [ID_W-1:0]   sid [4];
    logic [ID_W-1:0]   tid [4];
    logic              out0_vld;
    logic              out0_rdy = 1'b1;
    logic [DATA_W-1:0] out0_data;
    logic [ID_W-1:0]   out0_src_id;
    logic [ID_W-1:0]   out0_tgt_id;

    always #5 clk = ~clk;

    toy_bus_arb_node_arb_dmem_ack #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .in0_vld(vld[0]), .in0_rdy(rdy[0]), .in0_data(din[0]), .in0_src_id(sid[0]), .in0_tgt_id(tid[0]),
        .in1_vld(vld[1]), .in1_rdy(rdy[1]), .in1_data(din[1]), .in1_src_id(sid[1]), .in1_tgt_id(tid[1]),
        .in2_vld(vld[2]), .in2_rdy(rdy[2]), .in2_data(din[2]), .in2_src_id(sid[2]), .in2_tgt_id(tid[2]),
        .in3_vld(vld[3]), .in3_rdy(rdy[3]), .in3_data(din[3]), .in3_src_id(sid[3]), .in3_tgt_id(tid[3]),
        .out0_vld(out0_vld), .out0_rdy(out0_rdy), .out0_data(out0_data),
        .out0_src_id(out0_src_id), .out0_tgt_id(out0_tgt_id)
    );

    typedef struct packed {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] erdy;
        logic       eovld;
    } vec_t;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [ID_W-1:0]   s;
        logic [ID_W-1:0]   t;
    } beat_t;

    beat_t sb [$];
    beat_t last_beat = '0;
    int    n_cmp  = 0;
    int    n_fail = 0;
    vec_t  vecs [22];

    function automatic beat_t pay(int k, int tag);
        beat_t b;
        b.d = 32'hC0DE_0000 | DATA_W'(tag << 4) | DATA_W'(k);
        case (k)
            0:       b.s = 4'd3;
            1:       b.s = 4'd4;
            2:       b.s = 4'd5;
            default: b.s = 4'd7;
        endcase
        b.t = 4'd1;
        return b;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_beat();
        return 64'({out0_data, out0_src_id, out0_tgt_id});
    endfunction

    task automatic drive(logic [3:0] v, logic ordy, int tag);
        beat_t b;
        vld      = v;
        out0_rdy = ordy;
        for (int k = 0; k < 4; k++) begin
            b      = pay(k, tag);
            din[k] = b.d;
            sid[k] = b.s;
            tid[k] = b.t;
        end
    endtask

    // One vector: check handshake before the edge, queue the expected beat,
    // then check the registered output after the edge.
    task automatic step(vec_t x, int tag);
        drive(x.vld, x.ordy, tag);
        #1;
        chk($sformatf("vec%0d rdy", tag), 64'(rdy), 64'(x.erdy));
        for (int k = 0; k < 4; k++)
            if (x.erdy[k]) sb.push_back(pay(k, tag));
        @(posedge clk); #1;
        chk($sformatf("vec%0d out0_vld", tag), 64'(out0_vld), 64'(x.eovld));
        if (sb.size() > 0) begin
            last_beat = sb.pop_front();
            chk($sformatf("vec%0d payload", tag), out_beat(), 64'(last_beat));
        end else if (x.eovld) begin
            chk($sformatf("vec%0d held payload", tag), out_beat(), 64'(last_beat));
        end
    endtask

    initial begin
        // {vld, out0_rdy, expected rdy, expected out0_vld after edge}
        vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1};
        vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        vecs[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        vecs[8]  = '{4'b0010, 1'b0, 4'b0000, 1'b1};
        vecs[9]  = '{4'b0011, 1'b1, 4'b0001, 1'b1};
        vecs[10] = '{4'b0011, 1'b1, 4'b0010, 1'b1};
        vecs[11] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
        vecs[12] = '{4'b1000, 1'b1, 4'b1000, 1'b1};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        vecs[15] = '{4'b0110, 1'b0, 4'b0010, 1'b1};
        vecs[16] = '{4'b0110, 1'b0, 4'b0000, 1'b1};
        vecs[17] = '{4'b0110, 1'b1, 4'b0100, 1'b1};
        vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        vecs[19] = '{4'b0011, 1'b1, 4'b0001, 1'b1};
        vecs[20] = '{4'b0011, 1'b1, 4'b0010, 1'b1};
        vecs[21] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

        // Reset held 3 cycles with every channel requesting.
        drive(4'b1111, 1'b1, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset out0_vld", 64'(out0_vld), 64'd0);
            chk("reset rdy", 64'(rdy), 64'd0);
            chk("reset payload", out_beat(), 64'd0);
        end
        rst = 1'b0;
        #1;
        chk("first grant after reset", 64'(rdy), 64'b0001);
        vld = 4'b0000;
        #1;

        for (int v = 0; v < 22; v++) step(vecs[v], v);

        // Round-robin from a fresh reset: 0x10, 0x11, 0x12, 0x13, 0x10.
        rst = 1'b1;
        drive(4'b0000, 1'b1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(4'b1111, 1'b1, 0);
        for (int k = 0; k < 4; k++) din[k] = DATA_W'(32'h10 + k);
        for (int i = 0; i < 5; i++) begin
            beat_t b;
            #1;
            chk($sformatf("rr%0d rdy", i), 64'(rdy), 64'(4'b0001 << (i % 4)));
            b   = pay(i % 4, 0);
            b.d = DATA_W'(32'h10 + (i % 4));
            sb.push_back(b);
            @(posedge clk); #1;
            chk($sformatf("rr%0d out0_vld", i), 64'(out0_vld), 64'd1);
            last_beat = sb.pop_front();
            chk($sformatf("rr%0d payload", i), out_beat(), 64'(last_beat));
        end

        // Reset while a beat is stalled on the output.
        drive(4'b0000, 1'b1, 9);
        @(posedge clk); #1;
        drive(4'b0100, 1'b0, 9);
        #1;
        chk("stall load rdy", 64'(rdy), 64'b0100);
        @(posedge clk); #1;
        chk("stall out0_vld", 64'(out0_vld), 64'd1);
        vld = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid-stall reset out0_vld", 64'(out0_vld), 64'd0);
        chk("mid-stall reset payload", out_beat(), 64'd0);
        out0_rdy = 1'b1;
        @(posedge clk); #1;
        chk("stalled beat dropped", 64'(out0_vld), 64'd0);
        vld = 4'b1111;
        #1;
        chk("ptr cleared by reset", 64'(rdy), 64'b0001);
        vld = 4'b0000;
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/toy_bus_arb_node_arb_dmem_ack.md
# toy_bus_arb_node_arb_dmem_ack

Response-path merge node for the dmem initiator port of the toy bus. It collects acknowledge beats from the four targets the dmem request decoder routes to (tgt_id 3, 4, 5, 7 on input channels 0..3). A round-robin arbiter picks one beat per cycle and presents it to the dmem initiator through a single-entry output register. Full throughput is one beat per cycle when the output is continuously ready.

## Interface
Parameters:
- DATA_W, 32, response data width
- ID_W, 4, width of src_id/tgt_id fields

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high)
- inK_vld  in  1  response valid from channel K (K = 0..3)
- inK_rdy  out  1  channel K beat accepted this cycle when inK_vld is also high
- inK_data  in  DATA_W  response data, channel K
- inK_src_id  in  ID_W  responder id (3/4/5/7 for K = 0/1/2/3), channel K
- inK_tgt_id  in  ID_W  destination id (dmem initiator), channel K
- out0_vld  out  1  registered response valid to dmem
- out0_rdy  in  1  dmem accepts the response
- out0_data  out  DATA_W  registered data
- out0_src_id  out  ID_W  registered responder id
- out0_tgt_id  out  ID_W  registered destination id

## Operation
- State: output register {vld, data, src_id, tgt_id}; 2-bit round-robin pointer ptr.
- can_load = !out0_vld || out0_rdy.
- Grant is combinational and uses inK_vld and ptr only. It selects the first valid channel in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4). At most one grant is active.
- inK_rdy = grant_K && can_load. inK_rdy never depends on inK_vld of the same channel other than through the grant. No rdy is raised while no input is valid.
- Accept (some inK_vld && inK_rdy):
  - The output register loads channel K's payload and out0_vld is set to 1.
  - ptr becomes (K+1) mod 4.
- Output drained and no accept (out0_vld && out0_rdy, no input valid): out0_vld is cleared to 0. The payload holds its last value.
- Output stalled (out0_vld && !out0_rdy): register and ptr hold, and every inK_rdy is 0.
- Payload is passed through unmodified; the block does no tgt_id checking.
- Reset:
  - out0_vld = 0, out0_data/src_id/tgt_id = 0, ptr = 0, all inK_rdy = 0.
  - Reset asserted mid-transfer drops any registered beat. No beat is accepted in a cycle where rst = 1.

## Timing
- Latency is 1 cycle. A beat accepted at edge N appears on out0 after edge N.
- Throughput is 1 beat/cycle with out0_rdy held high; the register reloads in the same cycle it drains.
- Simultaneous drain and accept: out0_vld stays 1 and the new payload replaces the old one.
- Sources must hold vld and payload stable until rdy. A channel that drops vld before rdy is simply not granted.
- Fairness:
  - With all four channels continuously valid, grants rotate 0, 1, 2, 3, 0, and so on.
  - Any continuously valid channel is accepted within 4 accepts.
- ptr wraps from 3 to 0 with no special case.
- Out-of-reset: ptr = 0, so channel 0 has top priority on the first contention.

## Test plan
- Reset check:
  - Stimulus: hold rst = 1 for 3 cycles with all inK_vld = 1.
  - Required: out0_vld = 0, all inK_rdy = 0, out0 payload = 0.
  - After release, the first accept is channel 0.
- Single beat:
  - Stimulus: in2_vld = 1 with data 0xDEADBEEF, src_id 5, tgt_id 1; out0_rdy = 1.
  - Required: in2_rdy = 1 in the same cycle; next cycle out0_vld = 1 with 0xDEADBEEF/5/1; ptr becomes 3.
  - With no further input, out0_vld drops after the following cycle.
- Round-robin:
  - Stimulus: all four channels valid continuously with distinct data 0x10..0x13; out0_rdy = 1.
  - Required: out0 data sequence 0x10, 0x11, 0x12, 0x13, 0x10, with out0_vld high every cycle.
- Backpressure:
  - Stimulus: load one beat, then hold out0_rdy = 0 for 5 cycles with in1_vld = 1.
  - Required: out0 payload stable, in1_rdy = 0 throughout.
  - On out0_rdy = 1, in1 is accepted the same cycle and appears on out0 the next cycle.
- Pointer wrap and skip:
  - Stimulus: ptr = 3 (after a channel-2 accept); only in0 and in1 valid.
  - Required: in0 is granted, then ptr = 1, and in1 is granted next.
- Reset mid-stall:
  - Stimulus: out0_vld = 1 with out0_rdy = 0; assert rst for 1 cycle.
  - Required: out0_vld = 0 the next cycle, ptr = 0, and the stalled beat is not re-presented.
